gpio_pattern_gen: RTL and testbench
===================================

GPIO_PATTERN_GEN -- requirements
Module: gpio_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 9, the GPIO pattern width (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE_W, default 24, the prescaler width; one tick occurs every 2^PRESCALE_W enabled cycles.
REQ-003 SHALL have port clk  in  1  system clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port en  in  1  prescaler enable; the prescaler holds when low.
REQ-006 SHALL have port mode  in  2  pattern select: 0 rotate, 1 bounce, 2 binary count, 3 hold.
REQ-007 SHALL have port dir  in  1  direction: 0 up/left (toward MSB), 1 down/right.
REQ-008 SHALL have port step_i  in  1  manual single-step pulse, honoured regardless of en.
REQ-009 SHALL have port load  in  1  load strobe for load_val.
REQ-010 SHALL have port load_val  in  WIDTH  pattern value to load.
REQ-011 SHALL have port gpio_o  out  WIDTH  registered pattern output.
REQ-012 SHALL have port tick_o  out  1  one-cycle pulse on prescaler wrap.
REQ-013 SHALL have ports ledg / ledr  out  1 each  heartbeat LEDs.

Function
REQ-014 Prescaler: a PRESCALE_W-bit counter SHALL increment by 1 each cycle while en=1 and wrap from all-ones to 0.
REQ-015 tick_o SHALL be 1, registered, in the cycle after the counter holds all-ones with en=1; otherwise 0.
REQ-016 ledg SHALL equal the inverse of the prescaler MSB, and ledr SHALL equal the inverse of ledg.
REQ-017 A step event SHALL be tick_o=1 or step_i=1; both in one cycle SHALL produce exactly one advance.
REQ-018 Priority per cycle SHALL be: reset > load > mode change > step.
REQ-019 load=1 SHALL set gpio_o to load_val the next cycle, including a value of 0.
REQ-020 A mode change SHALL be detected as mode differing from its registered copy; it SHALL set gpio_o=1 and bounce_dir=up, and SHALL leave the prescaler undisturbed.
REQ-021 Mode 0 (rotate), on step:
  - dir=0: rotate left 1, so the MSB wraps to bit 0.
  - dir=1: rotate right 1, so bit 0 wraps to the MSB.
  - The pattern SHALL never decay to zero.
REQ-022 Mode 1 (bounce) SHALL keep an internal bounce_dir register and ignore dir. On step:
  - If going up and gpio_o[WIDTH-1]=1: bounce_dir flips to down and the pattern shifts right 1.
  - If going down and gpio_o[0]=1: bounce_dir flips to up and the pattern shifts left 1.
  - Otherwise: shift 1 in bounce_dir, zero-filled.
REQ-023 In modes 0 and 1, a step while gpio_o==0 SHALL load 1 (dir=0) or 1<<(WIDTH-1) (dir=1) instead of shifting.
REQ-024 Mode 2 (count), on step: gpio_o SHALL add 1 (dir=0) or subtract 1 (dir=1), modulo 2^WIDTH.
REQ-025 Mode 3 (hold): steps SHALL be ignored, while load and the prescaler SHALL still operate.
REQ-026 gpio_o SHALL change only on reset, load, mode change or step; all outputs are registered, except ledg/ledr, which are one inversion from a register.

Reset
REQ-027 While reset=1 at a clk edge, the block SHALL set:
  - prescaler = 0, tick_o = 0, gpio_o = 1;
  - bounce_dir = up, and the registered mode copy = mode;
  - so that ledg = 1 and ledr = 0 the next cycle.
REQ-028 Reset asserted mid-step, mid-load or mid-mode-change SHALL override all of them, and no event SHALL be retained afterwards.
REQ-029 The first step after reset release SHALL act on gpio_o=1; a mode held constant through reset SHALL NOT count as a change.

Verification (WIDTH=4, PRESCALE_W=2: tick every 4 enabled cycles)
REQ-030 Rotate wrap: mode=0, dir=0, en=1 from reset -> gpio_o steps 0001, 0010, 0100, 1000, 0001, one step per tick_o, with tick_o high 1 cycle in 4.
REQ-031 Bounce: mode=1 from reset, en=1 -> gpio_o sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-032 Count down wrap: mode=2, dir=1, load load_val=0000 -> next step gives 1111, then 1110.
REQ-033 Simultaneous events:
  - load=1 with load_val=1010, step_i=1 and tick in the same cycle -> gpio_o=1010, not shifted.
  - step_i=1 coinciding with tick_o -> single advance.
  - en=0 with step_i pulses -> one advance per pulse and the prescaler frozen.
REQ-034 Zero recovery and mode change:
  - mode=0, dir=1, load 0000, then step_i -> gpio_o=1000.
  - Switching mode 2->1 while gpio_o=0110 -> gpio_o=0001, with prescaler phase unchanged.
REQ-035 Reset mid-operation: reset=1 for one cycle while gpio_o=0100 in mode 1 going down -> gpio_o=0001, ledg=1, ledr=0; the next step gives 0010.

Source files
------------

// File: rtl/gpio_pattern_gen.sv
// GPIO pattern generator: prescaled rotate / bounce / count / hold patterns
// with manual stepping, parallel load and heartbeat LEDs.
module gpio_pattern_gen #(
  parameter int WIDTH      = 9,
  parameter int PRESCALE_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             step_i,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gpio_o,
  output logic             tick_o,
  output logic             ledg,
  output logic             ledr
);

  localparam logic [WIDTH-1:0]      ONE_C      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]      MSB_C      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [PRESCALE_W-1:0] PRESC_ONE_C = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_ROTATE_C = 2'd0;
  localparam logic [1:0] MODE_BOUNCE_C = 2'd1;
  localparam logic [1:0] MODE_COUNT_C  = 2'd2;
  localparam logic [1:0] MODE_HOLD_C   = 2'd3;

  logic [PRESCALE_W-1:0] presc_r;
  logic [PRESCALE_W-1:0] presc_nxt_s;
  logic [1:0]            mode_r;
  logic                  bounce_up_r;
  logic                  bounce_nxt_s;
  logic [WIDTH-1:0]      gpio_nxt_s;
  logic [WIDTH-1:0]      zero_seed_s;
  logic                  mode_chg_s;
  logic                  step_s;

  assign mode_chg_s  = (mode != mode_r);
  assign step_s      = tick_o | step_i;
  assign zero_seed_s = dir ? MSB_C : ONE_C;

  // Prescaler next value: advance only while enabled, wrapping naturally.
  always_comb begin
    presc_nxt_s = presc_r;
    if (en) begin
      presc_nxt_s = presc_r + PRESC_ONE_C;
    end else begin
      presc_nxt_s = presc_r;
    end
  end

  // Pattern next-state: load beats mode change beats step.
  always_comb begin
    gpio_nxt_s   = gpio_o;
    bounce_nxt_s = bounce_up_r;
    if (load) begin
      gpio_nxt_s = load_val;
    end else if (mode_chg_s) begin
      gpio_nxt_s   = ONE_C;
      bounce_nxt_s = 1'b1;
    end else if (step_s) begin
      case (mode_r)
        MODE_ROTATE_C: begin
          if (gpio_o == {WIDTH{1'b0}}) begin
            gpio_nxt_s = zero_seed_s;
          end else if (dir) begin
            gpio_nxt_s = {gpio_o[0], gpio_o[WIDTH-1:1]};
          end else begin
            gpio_nxt_s = {gpio_o[WIDTH-2:0], gpio_o[WIDTH-1]};
          end
        end
        MODE_BOUNCE_C: begin
          // Turn around at either end rather than sitting on the edge bit.
          if (gpio_o == {WIDTH{1'b0}}) begin
            gpio_nxt_s = zero_seed_s;
          end else if (bounce_up_r) begin
            if (gpio_o[WIDTH-1]) begin
              bounce_nxt_s = 1'b0;
              gpio_nxt_s   = {1'b0, gpio_o[WIDTH-1:1]};
            end else begin
              gpio_nxt_s   = {gpio_o[WIDTH-2:0], 1'b0};
            end
          end else begin
            if (gpio_o[0]) begin
              bounce_nxt_s = 1'b1;
              gpio_nxt_s   = {gpio_o[WIDTH-2:0], 1'b0};
            end else begin
              gpio_nxt_s   = {1'b0, gpio_o[WIDTH-1:1]};
            end
          end
        end
        MODE_COUNT_C: begin
          if (dir) begin
            gpio_nxt_s = gpio_o - ONE_C;
          end else begin
            gpio_nxt_s = gpio_o + ONE_C;
          end
        end
        MODE_HOLD_C: begin
          gpio_nxt_s = gpio_o;
        end
        default: begin
          gpio_nxt_s = gpio_o;
        end
      endcase
    end else begin
      gpio_nxt_s = gpio_o;
    end
  end

  // State registers; reset captures the current mode so it is not seen as a change.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r     <= {PRESCALE_W{1'b0}};
      tick_o      <= 1'b0;
      gpio_o      <= ONE_C;
      bounce_up_r <= 1'b1;
      mode_r      <= mode;
    end else begin
      presc_r     <= presc_nxt_s;
      tick_o      <= en & (&presc_r);
      gpio_o      <= gpio_nxt_s;
      bounce_up_r <= bounce_nxt_s;
      mode_r      <= mode;
    end
  end

  assign ledg = ~presc_r[PRESCALE_W-1];
  assign ledr = ~ledg;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Directed self-checking bench for gpio_pattern_gen (WIDTH=4, PRESCALE_W=2).
module tb_gpio_pattern_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       dir = 1'b0;
  logic       step_i = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] gpio_o;
  logic       tick_o;
  logic       ledg;
  logic       ledr;

  int n_assert = 0;
  int n_fail   = 0;

  gpio_pattern_gen #(.WIDTH(4), .PRESCALE_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
    .step_i(step_i), .load(load), .load_val(load_val),
    .gpio_o(gpio_o), .tick_o(tick_o), .ledg(ledg), .ledr(ledr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic pulse_step();
    step_i = 1'b1;
    cyc(1);
    step_i = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    while (!tick_o && waited < 16) begin
      cyc(1);
      waited++;
    end
    check_val("tick_seen", {31'd0, tick_o}, 32'd1);
  endtask

  logic [3:0] rot_exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] bnc_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

  initial begin
    int w;

    // Reset state and rotate-left wrap driven by the prescaler
    mode = 2'd0; dir = 1'b0; en = 1'b1;
    do_reset();
    check_val("rst_gpio", {28'd0, gpio_o}, 32'd1);
    check_val("rst_tick", {31'd0, tick_o}, 32'd0);
    check_val("rst_ledg", {31'd0, ledg}, 32'd1);
    check_val("rst_ledr", {31'd0, ledr}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wait_tick(w);
      check_val("rot_period", w, (i == 0) ? 32'd4 : 32'd3);
      cyc(1);
      check_val("rot_step", {28'd0, gpio_o}, {28'd0, rot_exp[i]});
      check_val("tick_width", {31'd0, tick_o}, 32'd0);
    end

    // Bounce sequence
    mode = 2'd1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wait_tick(w);
      cyc(1);
      check_val("bounce_step", {28'd0, gpio_o}, {28'd0, bnc_exp[i]});
    end

    // Heartbeat LEDs and hold mode
    mode = 2'd3;
    do_reset();
    cyc(2);
    check_val("led_g_low", {31'd0, ledg}, 32'd0);
    check_val("led_r_high", {31'd0, ledr}, 32'd1);
    cyc(2);
    check_val("led_g_wrap", {31'd0, ledg}, 32'd1);
    check_val("led_tick", {31'd0, tick_o}, 32'd1);
    cyc(1);
    check_val("hold_tick", {28'd0, gpio_o}, 32'd1);
    pulse_step();
    check_val("hold_step", {28'd0, gpio_o}, 32'd1);
    do_load(4'b0101);
    check_val("hold_load", {28'd0, gpio_o}, 32'h5);

    // Count down wrap from a loaded zero, then count up wrap
    mode = 2'd2; dir = 1'b1; en = 1'b0;
    do_reset();
    do_load(4'b0000);
    check_val("cnt_load0", {28'd0, gpio_o}, 32'h0);
    pulse_step();
    check_val("cnt_dn_wrap", {28'd0, gpio_o}, 32'hf);
    pulse_step();
    check_val("cnt_dn", {28'd0, gpio_o}, 32'he);
    dir = 1'b0;
    pulse_step();
    check_val("cnt_up", {28'd0, gpio_o}, 32'hf);
    pulse_step();
    check_val("cnt_up_wrap", {28'd0, gpio_o}, 32'h0);

    // Simultaneous events
    en = 1'b1;
    do_reset();
    wait_tick(w);
    load = 1'b1; load_val = 4'b1010; step_i = 1'b1;
    cyc(1);
    load = 1'b0; step_i = 1'b0;
    check_val("load_wins", {28'd0, gpio_o}, 32'ha);
    wait_tick(w);
    check_val("pre_dual", {28'd0, gpio_o}, 32'ha);
    step_i = 1'b1;
    cyc(1);
    step_i = 1'b0;
    en = 1'b0;
    check_val("dual_single", {28'd0, gpio_o}, 32'hb);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      check_val("manual_step", {28'd0, gpio_o}, 32'hc + i);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check_val("frozen_tick", {31'd0, tick_o}, 32'd0);
    end
    check_val("frozen_gpio", {28'd0, gpio_o}, 32'he);
    check_val("frozen_ledg", {31'd0, ledg}, 32'd1);

    // Zero recovery in rotate and bounce
    mode = 2'd0; dir = 1'b1;
    do_reset();
    pulse_step();
    check_val("rot_right", {28'd0, gpio_o}, 32'h8);
    do_load(4'b0000);
    pulse_step();
    check_val("rot_zero_dn", {28'd0, gpio_o}, 32'h8);
    pulse_step();
    check_val("rot_right2", {28'd0, gpio_o}, 32'h4);
    mode = 2'd1; dir = 1'b0;
    do_reset();
    do_load(4'b0000);
    pulse_step();
    check_val("bnc_zero_up", {28'd0, gpio_o}, 32'h1);

    // Mode change 2 -> 1 keeps prescaler phase
    mode = 2'd2; en = 1'b1;
    do_reset();
    do_load(4'b0110);
    check_val("mc_load", {28'd0, gpio_o}, 32'h6);
    mode = 2'd1;
    cyc(1);
    check_val("mc_gpio", {28'd0, gpio_o}, 32'h1);
    wait_tick(w);
    check_val("mc_phase", w, 32'd2);
    cyc(1);
    check_val("mc_bounce_up", {28'd0, gpio_o}, 32'h2);

    // Reset in the middle of a bounce going down, with competing events
    mode = 2'd1; en = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) pulse_step();
    check_val("mid_before", {28'd0, gpio_o}, 32'h4);
    reset = 1'b1; step_i = 1'b1; load = 1'b1; load_val = 4'hf;
    cyc(1);
    reset = 1'b0; step_i = 1'b0; load = 1'b0;
    check_val("mid_gpio", {28'd0, gpio_o}, 32'h1);
    check_val("mid_ledg", {31'd0, ledg}, 32'd1);
    check_val("mid_ledr", {31'd0, ledr}, 32'd0);
    check_val("mid_tick", {31'd0, tick_o}, 32'd0);
    cyc(1);
    check_val("mid_no_retain", {28'd0, gpio_o}, 32'h1);
    pulse_step();
    check_val("mid_next", {28'd0, gpio_o}, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
